dffre_selftest_seq: RTL and testbench
=====================================

// Module: dffre_selftest_seq
// PURPOSE
//  On-chip stimulus sequencer and lockstep checker for the dffre_inst benchmark.
//  Drives one shared Reset/Enable/D stimulus into the golden and post-route copies.
//  Samples both Q outputs at the end of each step and counts mismatches.
//  Also checks golden Q against an expected-value table; reports done/pass.
// PARAMETERS
//  HOLD_CYCLES  2   cycles each stimulus step is held; must be >= 2
//  TAIL_CYCLES  10  idle cycles after the last step before DONE; 0 allowed
//  CNT_W        8   mismatch counter width
// PORTS
//  clk             in   1       single clock, rising edge
//  i_Reset         in   1       synchronous, active-high reset
//  i_Start         in   1       1-cycle start pulse; honoured only in IDLE or DONE
//  i_Q_golden      in   1       Q from the golden dffre_inst copy
//  i_Q_netlist     in   1       Q from the post-route copy
//  o_Dut_Reset     out  1       stimulus reset to both copies
//  o_Dut_Enable    out  1       stimulus enable to both copies
//  o_Dut_D         out  1       stimulus data to both copies
//  o_Step          out  3       current step index, 0..5
//  o_Busy          out  1       high in APPLY and TAIL
//  o_Done          out  1       high in DONE
//  o_Pass          out  1       o_Done & no mismatch & no golden error
//  o_Mismatch_Cnt  out  CNT_W   golden!=netlist compare count; saturates at all-ones
//  o_First_Err     out  3       step of the first mismatch; valid when cnt != 0
//  o_Golden_Err    out  1       sticky: golden Q != table expectation at any compare
// BEHAVIOUR
//  - Reset values: o_Dut_Reset=1, o_Dut_Enable=0, o_Dut_D=0.
//    All other outputs are 0. State is IDLE.
//  - i_Reset is synchronous. Asserting it at any cycle, including mid-APPLY,
//    returns to IDLE with the reset values on the next edge.
//  - Step table (Reset,Enable,D -> expected Q):
//    0:(1,0,1)->0  1:(0,0,1)->0  2:(0,0,1)->0
//    3:(0,1,1)->1  4:(0,1,0)->0  5:(0,1,1)->1
//  - IDLE: i_Start -> APPLY with step=0. Counter, o_First_Err and o_Golden_Err clear.
//    Stimulus outputs are registered and take the step-0 values 1 cycle after i_Start.
//  - APPLY: hold counter h runs 0..HOLD_CYCLES-1; stimulus is constant while h runs.
//    At h==HOLD_CYCLES-1, sample the inputs:
//    * i_Q_golden!=i_Q_netlist -> counter+1 (saturating);
//      if counter was 0, o_First_Err<=step.
//    * i_Q_golden!=expected -> o_Golden_Err<=1.
//    Then step+1 with h=0. After step 5 -> TAIL.
//  - TAIL: stimulus frozen at the step-5 values for TAIL_CYCLES cycles -> DONE.
//    TAIL_CYCLES=0 goes straight to DONE.
//  - DONE: status held. o_Dut_Reset returns to 1. i_Start restarts exactly as from IDLE.
//  - i_Start in APPLY or TAIL is ignored.
//  - i_Reset and i_Start in the same cycle: reset wins.
//  - Compare is 2-state: X on an input is not detected in RTL.
//    The bench checks for X separately with !==.
//  - Timing: step k holds cycles [1+k*HOLD_CYCLES, (k+1)*HOLD_CYCLES] after start.
//    Done rises at cycle 1+6*HOLD_CYCLES+TAIL_CYCLES after the i_Start edge.
// STRUCTURE
//  - dffre_selftest_pkg holds:
//    * typedef enum {IDLE,APPLY,TAIL,DONE} state_t
//    * typedef struct packed {rst,en,d,exp_q} step_t
//    * localparam NUM_STEPS=6
//    * the constant step_t STEP_TABLE[NUM_STEPS]
//  - One sub-module: selftest_sat_cnt, a parameterised saturating up-counter
//    with sync clear and enable, used for o_Mismatch_Cnt.
//  - The hold and tail counters are inline.
// TESTING
//  1. Tie i_Q_netlist=i_Q_golden to a behavioural dffre; pulse i_Start.
//     -> o_Done at cycle 23 (defaults), o_Pass=1, cnt=0, o_Golden_Err=0.
//  2. Force i_Q_netlist=~i_Q_golden during step 4 only.
//     -> cnt=1, o_First_Err=4, o_Pass=0, o_Golden_Err=0.
//  3. Netlist stuck at 0 with a correct golden.
//     -> mismatches at steps 3 and 5, cnt=2, o_First_Err=3.
//  4. CNT_W=1, netlist always inverted.
//     -> cnt saturates at 1, o_First_Err=0, no wrap.
//  5. Golden model stuck at 1.
//     -> o_Golden_Err=1, o_Pass=0.
//  6. Assert i_Reset at step 2, h=1.
//     -> next cycle: IDLE, o_Dut_Reset=1, cnt=0, o_Busy=0.
//     i_Start during APPLY is ignored; i_Start in DONE reruns and clears status.

Source files
------------

// File: rtl/dffre_selftest_pkg.sv
// Shared types and the stimulus/expectation table for the dffre_inst self-test sequencer.
package dffre_selftest_pkg;

  localparam int unsigned NUM_STEPS = 6;
  localparam int unsigned STEP_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    TAIL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic rst;
    logic en;
    logic d;
    logic exp_q;
  } step_t;

  // Reset, hold-through-disable, capture 1, capture 0, capture 1.
  localparam step_t STEP_TABLE [NUM_STEPS] = '{
    '{rst: 1'b1, en: 1'b0, d: 1'b1, exp_q: 1'b0},
    '{rst: 1'b0, en: 1'b0, d: 1'b1, exp_q: 1'b0},
    '{rst: 1'b0, en: 1'b0, d: 1'b1, exp_q: 1'b0},
    '{rst: 1'b0, en: 1'b1, d: 1'b1, exp_q: 1'b1},
    '{rst: 1'b0, en: 1'b1, d: 1'b0, exp_q: 1'b0},
    '{rst: 1'b0, en: 1'b1, d: 1'b1, exp_q: 1'b1}
  };

  // Packs the stimulus fields as {reset, enable, d}.
  function automatic logic [2:0] stim_bits(input step_t s);
    return {s.rst, s.en, s.d};
  endfunction

endpackage

// File: rtl/selftest_sat_cnt.sv
// Saturating up-counter with synchronous reset/clear and count enable.
module selftest_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dffre_selftest_seq.sv
// Stimulus sequencer and lockstep golden/netlist checker for dffre_inst.
module dffre_selftest_seq
  import dffre_selftest_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TAIL_CYCLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic              i_Q_golden,
  input  logic              i_Q_netlist,
  output logic              o_Dut_Reset,
  output logic              o_Dut_Enable,
  output logic              o_Dut_D,
  output logic [STEP_W-1:0] o_Step,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Pass,
  output logic [CNT_W-1:0]  o_Mismatch_Cnt,
  output logic [STEP_W-1:0] o_First_Err,
  output logic              o_Golden_Err
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam int unsigned TAIL_W = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'((TAIL_CYCLES == 0) ? 0 : TAIL_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TAIL_W-1:0]   tail_q, tail_d;
  logic [STEP_W-1:0]   step_d;
  logic [2:0]          stim_d;
  logic [STEP_W-1:0]   ferr_d;
  logic                gerr_d;
  logic                busy_d, done_d, pass_d;
  logic                cnt_clr, cnt_inc, cnt_zero, mismatch;

  assign cnt_zero = (o_Mismatch_Cnt == '0);
  assign mismatch = i_Q_golden ^ i_Q_netlist;

  selftest_sat_cnt #(.W(CNT_W)) u_mismatch_cnt (
    .clk (clk),
    .rst (i_Reset),
    .clr (cnt_clr),
    .en  (cnt_inc),
    .cnt (o_Mismatch_Cnt)
  );

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (i_Reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      tail_q       <= '0;
      o_Step       <= '0;
      o_Dut_Reset  <= 1'b1;
      o_Dut_Enable <= 1'b0;
      o_Dut_D      <= 1'b0;
      o_Busy       <= 1'b0;
      o_Done       <= 1'b0;
      o_Pass       <= 1'b0;
      o_First_Err  <= '0;
      o_Golden_Err <= 1'b0;
    end else begin
      state_q                                <= state_d;
      hold_q                                 <= hold_d;
      tail_q                                 <= tail_d;
      o_Step                                 <= step_d;
      {o_Dut_Reset, o_Dut_Enable, o_Dut_D}   <= stim_d;
      o_Busy                                 <= busy_d;
      o_Done                                 <= done_d;
      o_Pass                                 <= pass_d;
      o_First_Err                            <= ferr_d;
      o_Golden_Err                           <= gerr_d;
    end
  end

  // Next-state, step sequencing and compare logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tail_d  = tail_q;
    step_d  = o_Step;
    stim_d  = {o_Dut_Reset, o_Dut_Enable, o_Dut_D};
    ferr_d  = o_First_Err;
    gerr_d  = o_Golden_Err;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_Start) begin
          state_d = APPLY;
          hold_d  = '0;
          tail_d  = '0;
          step_d  = '0;
          stim_d  = stim_bits(STEP_TABLE[0]);
          cnt_clr = 1'b1;
          ferr_d  = '0;
          gerr_d  = 1'b0;
        end
      end
      APPLY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          cnt_inc = mismatch;
          if (mismatch && cnt_zero) begin
            ferr_d = o_Step;
          end
          if (i_Q_golden != STEP_TABLE[o_Step].exp_q) begin
            gerr_d = 1'b1;
          end
          if (o_Step == STEP_LAST) begin
            if (TAIL_CYCLES == 0) begin
              state_d   = DONE;
              stim_d[2] = 1'b1;
            end else begin
              state_d = TAIL;
            end
          end else begin
            step_d = o_Step + STEP_W'(1);
            stim_d = stim_bits(STEP_TABLE[step_d]);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      TAIL: begin
        if (tail_q == TAIL_LAST) begin
          state_d   = DONE;
          tail_d    = '0;
          stim_d[2] = 1'b1;
        end else begin
          tail_d = tail_q + TAIL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == TAIL);
    done_d = (state_d == DONE);
    // Pass must account for a compare landing on the same edge that enters DONE.
    pass_d = done_d && cnt_zero && !cnt_inc && !gerr_d;
  end

endmodule

// File: tb/tb_dffre_selftest_seq.sv
// Randomized fault-injection bench for dffre_selftest_seq using a per-step outcome model.
module tb_dffre_selftest_seq;

  localparam int HA = 2;
  localparam int TA = 10;
  localparam int HB = 3;
  localparam int TB = 0;

  logic clk = 1'b0;
  logic rst, start_a, start_b, sel;
  logic nstuck0, gstuck1, nflip_cur, gflip_cur;

  logic       a_rst, a_en, a_d, a_busy, a_done, a_pass, a_gerr;
  logic [2:0] a_step, a_ferr;
  logic [7:0] a_cnt;
  logic       b_rst, b_en, b_d, b_busy, b_done, b_pass, b_gerr;
  logic [2:0] b_step, b_ferr;
  logic [0:0] b_cnt;

  logic qa, qb, ga, gb, na, nb;

  logic       o_rst, o_en, o_d, o_busy, o_done, o_pass, o_gerr;
  logic [2:0] o_step, o_ferr;
  logic [7:0] o_cnt;

  int checks = 0;
  int failures = 0;

  logic [2:0] stim_tbl [6] = '{3'b101, 3'b001, 3'b001, 3'b011, 3'b010, 3'b011};
  logic [5:0] expq = 6'b101000;

  always #5 clk = ~clk;

  dffre_selftest_seq dut_a (
    .clk(clk), .i_Reset(rst), .i_Start(start_a), .i_Q_golden(ga), .i_Q_netlist(na),
    .o_Dut_Reset(a_rst), .o_Dut_Enable(a_en), .o_Dut_D(a_d), .o_Step(a_step),
    .o_Busy(a_busy), .o_Done(a_done), .o_Pass(a_pass), .o_Mismatch_Cnt(a_cnt),
    .o_First_Err(a_ferr), .o_Golden_Err(a_gerr)
  );

  dffre_selftest_seq #(.HOLD_CYCLES(HB), .TAIL_CYCLES(TB), .CNT_W(1)) dut_b (
    .clk(clk), .i_Reset(rst), .i_Start(start_b), .i_Q_golden(gb), .i_Q_netlist(nb),
    .o_Dut_Reset(b_rst), .o_Dut_Enable(b_en), .o_Dut_D(b_d), .o_Step(b_step),
    .o_Busy(b_busy), .o_Done(b_done), .o_Pass(b_pass), .o_Mismatch_Cnt(b_cnt),
    .o_First_Err(b_ferr), .o_Golden_Err(b_gerr)
  );

  // Behavioural dffre copies driven by each sequencer's stimulus.
  always @(posedge clk) begin
    if (a_rst) qa <= 1'b0; else if (a_en) qa <= a_d;
    if (b_rst) qb <= 1'b0; else if (b_en) qb <= b_d;
  end

  assign ga = gstuck1 ? 1'b1 : (qa ^ gflip_cur);
  assign na = nstuck0 ? 1'b0 : (ga ^ nflip_cur);
  assign gb = gstuck1 ? 1'b1 : (qb ^ gflip_cur);
  assign nb = nstuck0 ? 1'b0 : (gb ^ nflip_cur);

  always_comb begin
    o_rst  = sel ? b_rst  : a_rst;
    o_en   = sel ? b_en   : a_en;
    o_d    = sel ? b_d    : a_d;
    o_busy = sel ? b_busy : a_busy;
    o_done = sel ? b_done : a_done;
    o_pass = sel ? b_pass : a_pass;
    o_gerr = sel ? b_gerr : a_gerr;
    o_step = sel ? b_step : a_step;
    o_ferr = sel ? b_ferr : a_ferr;
    o_cnt  = sel ? {7'b0, b_cnt} : a_cnt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // One full sequence; nf/gf are per-step netlist/golden inversion masks.
  task automatic run(input string name, input logic [5:0] nf, input logic [5:0] gf,
                     input logic ns0, input logic gs1, input int x1, input int x2);
    int h, t, wmax, exp_done, mcnt, first, c, k;
    logic gerr, g, n, done_seen;
    h = sel ? HB : HA;
    t = sel ? TB : TA;
    wmax = sel ? 1 : 255;
    exp_done = 1 + 6 * h + t;
    mcnt = 0; first = 0; gerr = 1'b0;
    for (int s = 0; s < 6; s++) begin
      g = gs1 ? 1'b1 : (expq[s] ^ gf[s]);
      n = ns0 ? 1'b0 : (g ^ nf[s]);
      if (g != n) begin
        if (mcnt == 0) first = s;
        mcnt++;
      end
      if (g != expq[s]) gerr = 1'b1;
    end
    if (mcnt > wmax) mcnt = wmax;

    nstuck0 = ns0; gstuck1 = gs1; nflip_cur = 1'b0; gflip_cur = 1'b0;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    c = 1;
    done_seen = 1'b0;
    while (!done_seen && c <= 200) begin
      set_start((c == x1) || (c == x2));
      if (c <= 6 * h) begin
        k = (c - 1) / h;
        nflip_cur = nf[k];
        gflip_cur = gf[k];
        if (c == 1 || ((c - 1) % h) == h - 1) begin
          check({name, "_stim"}, 32'({o_rst, o_en, o_d}), 32'(stim_tbl[k]));
          check({name, "_step"}, 32'(o_step), 32'(k));
          check({name, "_busy"}, 32'(o_busy), 32'd1);
        end
      end else begin
        nflip_cur = 1'b0;
        gflip_cur = 1'b0;
      end
      if (o_done === 1'b1) begin
        done_seen = 1'b1;
        check({name, "_done_cycle"}, 32'(c), 32'(exp_done));
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    set_start(1'b0);
    if (!done_seen) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_pass"}, 32'(o_pass), 32'((mcnt == 0) && !gerr));
      check({name, "_cnt"}, 32'(o_cnt), 32'(mcnt));
      check({name, "_gerr"}, 32'(o_gerr), 32'(gerr));
      if (mcnt != 0) check({name, "_first_err"}, 32'(o_ferr), 32'(first));
      check({name, "_busy_done"}, 32'(o_busy), 32'd0);
      check({name, "_dut_rst_done"}, 32'(o_rst), 32'd1);
      @(posedge clk); #1;
      check({name, "_done_held"}, 32'({o_done, o_pass}), 32'({1'b1, (mcnt == 0) && !gerr}));
      check({name, "_cnt_held"}, 32'(o_cnt), 32'(mcnt));
    end
  endtask

  // Reset lands at step 2, h=1 together with a start pulse; reset must win.
  task automatic reset_mid();
    nstuck0 = 1'b0; gstuck1 = 1'b0; gflip_cur = 1'b0; nflip_cur = 1'b1;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    for (int c = 1; c < 6; c++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_pre_cnt", 32'(o_cnt), 32'd2);
    rst = 1'b1;
    set_start(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_start(1'b0);
    nflip_cur = 1'b0;
    check("rst_mid_stim", 32'({o_rst, o_en, o_d}), 32'(3'b100));
    check("rst_mid_status", 32'({o_busy, o_done, o_pass, o_gerr}), 32'd0);
    check("rst_mid_cnt", 32'(o_cnt), 32'd0);
    check("rst_mid_step_ferr", 32'({o_step, o_ferr}), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_stays_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    nstuck0 = 1'b0; gstuck1 = 1'b0; nflip_cur = 1'b0; gflip_cur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check("reset_stim", 32'({o_rst, o_en, o_d}), 32'(3'b100));
      check("reset_status", 32'({o_busy, o_done, o_pass, o_gerr}), 32'd0);
      check("reset_cnt_step_ferr", 32'({o_cnt, o_step, o_ferr}), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run("clean", 6'h00, 6'h00, 1'b0, 1'b0, 5, 16);
    run("step4", 6'b010000, 6'h00, 1'b0, 1'b0, -1, -1);
    run("nstuck0", 6'h00, 6'h00, 1'b1, 1'b0, -1, -1);
    run("gstuck1", 6'h00, 6'h00, 1'b0, 1'b1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      run("rand_a", 6'($urandom), 6'($urandom), 1'b0, 1'b0, int'($urandom_range(2, 20)), -1);
    end
    reset_mid();
    run("after_rst", 6'h00, 6'h00, 1'b0, 1'b0, -1, -1);

    sel = 1'b1;
    run("b_inv", 6'h3f, 6'h00, 1'b0, 1'b0, 4, -1);
    for (int r = 0; r < 3; r++) begin
      run("rand_b", 6'($urandom), 6'($urandom), 1'b0, 1'b0, -1, -1);
    end
    run("b_clean", 6'h00, 6'h00, 1'b0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
